// File: rtl/life_ctrl_pkg.sv
// Shared types and constants for the Game-of-Life generation sequencer,
// its cell array and scratch memory.
package life_ctrl_pkg;

  localparam int POS_COUNT_DEF = 4;
  localparam int GEN_W_DEF = 16;
  localparam int PHASES_PER_POS = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_WMEM   = 3'd3,
    S_ADV    = 3'd4,
    S_COMMIT = 3'd5
  } state_e;

  function automatic int gen_cycles(input int pos_count);
    return PHASES_PER_POS * pos_count + 1;
  endfunction

endpackage

// File: rtl/life_pos_counter.sv
// Modulo-POS_COUNT position counter.
// Wraps explicitly so non-power-of-two depths never leave the valid range.
module life_pos_counter
  import life_ctrl_pkg::*;
#(
  parameter int POS_COUNT = POS_COUNT_DEF,
  localparam int POS_W = $clog2(POS_COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [POS_W-1:0] pos,
  output logic             last
);

  assign last = (pos == POS_W'(POS_COUNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
    end else if (clr) begin
      pos <= '0;
    end else if (inc) begin
      pos <= last ? '0 : pos + 1'b1;
    end
  end

endmodule

// File: rtl/life_gen_controller.sv
// Sequences one Game-of-Life generation over all cell positions and
// commits the scratch memory to the display array.
module life_gen_controller
  import life_ctrl_pkg::*;
#(
  parameter int POS_COUNT = POS_COUNT_DEF,
  parameter int GEN_W = GEN_W_DEF,
  localparam int POS_W = $clog2(POS_COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step_mode,
  output logic [POS_W-1:0] pos,
  output logic             run,
  output logic             write_mem,
  output logic             write_array,
  output logic             busy,
  output logic             gen_done,
  output logic [GEN_W-1:0] gen_count
);

  state_e state;
  state_e state_nxt;
  logic   stop_pending;
  logic   pos_inc;
  logic   pos_clr;
  logic   pos_last;

  life_pos_counter #(
    .POS_COUNT(POS_COUNT)
  ) u_pos (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (pos_inc),
    .clr  (pos_clr),
    .pos  (pos),
    .last (pos_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pos_inc   = 1'b0;
    pos_clr   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_nxt = S_LOAD;
          pos_clr   = 1'b1;
        end
      end
      S_LOAD: state_nxt = S_RUN;
      S_RUN:  state_nxt = S_WMEM;
      S_WMEM: state_nxt = S_ADV;
      S_ADV: begin
        if (pos_last) begin
          state_nxt = S_COMMIT;
        end else begin
          state_nxt = S_LOAD;
          pos_inc   = 1'b1;
        end
      end
      S_COMMIT: begin
        pos_clr = 1'b1;
        if (step_mode || stop_pending || stop) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_LOAD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A stop seen while busy waits for the generation to finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop_pending <= 1'b0;
    end else if (state_nxt == S_IDLE) begin
      stop_pending <= 1'b0;
    end else if (busy && stop) begin
      stop_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_count <= '0;
    end else if (state == S_COMMIT) begin
      gen_count <= gen_count + 1'b1;
    end
  end

  assign busy        = (state != S_IDLE);
  assign run         = (state == S_RUN);
  assign write_mem   = (state == S_WMEM);
  assign write_array = (state == S_COMMIT);
  assign gen_done    = (state == S_COMMIT);

endmodule

// File: tb/tb_life_gen_controller.sv
// Bench for life_gen_controller: two instances (4 positions/16-bit count,
// 5 positions/2-bit count) checked against a generation-level model.
module tb_life_gen_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic stop;
  logic step_mode;

  always #5 clk = ~clk;

  logic [1:0]  pos_a;
  logic        run_a, wm_a, wa_a, busy_a, gd_a;
  logic [15:0] gc_a;
  logic [2:0]  pos_b;
  logic        run_b, wm_b, wa_b, busy_b, gd_b;
  logic [1:0]  gc_b;

  life_gen_controller #(.POS_COUNT(4), .GEN_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .step_mode(step_mode), .pos(pos_a), .run(run_a),
    .write_mem(wm_a), .write_array(wa_a), .busy(busy_a),
    .gen_done(gd_a), .gen_count(gc_a)
  );

  life_gen_controller #(.POS_COUNT(5), .GEN_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .step_mode(step_mode), .pos(pos_b), .run(run_b),
    .write_mem(wm_b), .write_array(wa_b), .busy(busy_b),
    .gen_done(gd_b), .gen_count(gc_b)
  );

  wire [23:0] obs_a = {busy_a, run_a, wm_a, wa_a, gd_a, 1'b0, pos_a, gc_a};
  wire [23:0] obs_b = {busy_b, run_b, wm_b, wa_b, gd_b, pos_b, 14'd0, gc_b};

  int errors = 0;
  int checks = 0;

  int pc[2] = '{4, 5};
  int gw[2] = '{16, 2};
  bit mbusy[2];
  int mk[2];
  int mgc[2];
  bit msp[2];

  // Model: while busy, mk counts cycles 0..4P within a generation;
  // cycle 4P is the commit cycle, others are (pos = k/4, phase = k%4).
  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mbusy[i] = 0; mk[i] = 0; mgc[i] = 0; msp[i] = 0;
    end
  endfunction

  function automatic void model_tick();
    for (int i = 0; i < 2; i++) begin
      if (!mbusy[i]) begin
        if (start && !stop) begin
          mbusy[i] = 1; mk[i] = 0;
        end
      end else if (mk[i] < 4 * pc[i]) begin
        mk[i]++;
        if (stop) msp[i] = 1;
      end else begin
        mgc[i] = (mgc[i] + 1) % (1 << gw[i]);
        if (step_mode || msp[i] || stop) begin
          mbusy[i] = 0; msp[i] = 0;
        end else begin
          mk[i] = 0;
        end
      end
    end
  endfunction

  function automatic logic [23:0] exp_vec(input int i);
    logic [23:0] v;
    v = '0;
    if (i == 0) v[15:0] = 16'(mgc[i]);
    else v[1:0] = 2'(mgc[i]);
    if (mbusy[i]) begin
      v[23] = 1'b1;
      if (mk[i] == 4 * pc[i]) begin
        v[20] = 1'b1;
        v[19] = 1'b1;
        if (i == 0) v[17:16] = 2'(pc[i] - 1);
        else v[18:16] = 3'(pc[i] - 1);
      end else begin
        if (i == 0) v[17:16] = 2'(mk[i] / 4);
        else v[18:16] = 3'(mk[i] / 4);
        v[22] = (mk[i] % 4 == 1);
        v[21] = (mk[i] % 4 == 2);
      end
    end
    return v;
  endfunction

  task automatic tick(input bit s, input bit t);
    start = s;
    stop  = t;
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; stop = 0; step_mode = 0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs_a !== exp_vec(0)) begin
      errors++; $display("FAIL reset_a got=%h want=%h", obs_a, exp_vec(0));
    end
    checks++;
    if (obs_b !== exp_vec(1)) begin
      errors++; $display("FAIL reset_b got=%h want=%h", obs_b, exp_vec(1));
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_step_mode();
    int wa_cnt = 0;
    step_mode = 1'b1;
    tick(1, 0);
    for (int c = 0; c < 24; c++) begin
      checks++;
      if (obs_a !== exp_vec(0)) begin
        errors++; $display("FAIL step_a c=%0d got=%h want=%h", c, obs_a, exp_vec(0));
      end
      checks++;
      if (obs_b !== exp_vec(1)) begin
        errors++; $display("FAIL step_b c=%0d got=%h want=%h", c, obs_b, exp_vec(1));
      end
      if (wa_a) wa_cnt++;
      tick(0, 0);
    end
    checks++;
    if (wa_cnt != 1 || gc_a !== 16'd1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL step_summary got wa=%0d gc=%0d busy=%b want wa=1 gc=1 busy=0",
               wa_cnt, gc_a, busy_a);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((mbusy[0] || mbusy[1]) && n < 100) begin
      tick(0, 1);
      n++;
      checks++;
      if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
        errors++;
        $display("FAIL drain got=%h/%h want=%h/%h", obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
    end
    checks++;
    if (n >= 100) begin
      errors++; $display("FAIL drain_timeout got=busy want=idle");
    end
  endtask

  task automatic test_back_to_back();
    int gd_cnt = 0;
    int base = mgc[0];
    step_mode = 1'b0;
    tick(1, 0);
    for (int c = 0; c < 51; c++) begin
      tick(0, 0);
      checks++;
      if (obs_a !== exp_vec(0)) begin
        errors++; $display("FAIL b2b_a c=%0d got=%h want=%h", c, obs_a, exp_vec(0));
      end
      checks++;
      if (obs_b !== exp_vec(1)) begin
        errors++; $display("FAIL b2b_b c=%0d got=%h want=%h", c, obs_b, exp_vec(1));
      end
      if (gd_a) gd_cnt++;
    end
    checks++;
    if (gd_cnt != 3 || gc_a !== 16'(base + 3)) begin
      errors++;
      $display("FAIL b2b_count got gd=%0d gc=%0d want gd=3 gc=%0d", gd_cnt, gc_a, base + 3);
    end
    drain();
  endtask

  task automatic test_stop();
    int wa_cnt = 0;
    int n = 0;
    int base = mgc[0];
    step_mode = 1'b0;
    tick(1, 0);
    while (!(wa_cnt == 1 && mk[0] == 5) && n < 60) begin
      if (wa_a) wa_cnt++;
      tick(0, 0);
      n++;
    end
    checks++;
    if (run_a !== 1'b1 || pos_a !== 2'd1) begin
      errors++; $display("FAIL stop_point got run=%b pos=%0d want run=1 pos=1", run_a, pos_a);
    end
    tick(0, 1);
    n = 0;
    while ((mbusy[0] || mbusy[1]) && n < 60) begin
      checks++;
      if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
        errors++;
        $display("FAIL stop_run got=%h/%h want=%h/%h", obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
      if (wa_a) wa_cnt++;
      tick(0, 0);
      n++;
    end
    repeat (3) tick(0, 0);
    checks++;
    if (wa_cnt != 2 || gc_a !== 16'(base + 2) || busy_a !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL stop_summary got wa=%0d gc=%0d busy=%b%b want wa=2 gc=%0d busy=00",
               wa_cnt, gc_a, busy_a, busy_b, base + 2);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    step_mode = 1'b0;
    tick(1, 0);
    while (mk[0] != 10 && n < 40) begin
      tick(0, 0);
      n++;
    end
    checks++;
    if (wm_a !== 1'b1 || pos_a !== 2'd2) begin
      errors++; $display("FAIL arst_point got wm=%b pos=%0d want wm=1 pos=2", wm_a, pos_a);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_a !== 24'd0 || obs_b !== 24'd0) begin
      errors++; $display("FAIL arst_zero got=%h/%h want=0/0", obs_a, obs_b);
    end
    @(negedge clk);
    checks++;
    if (wa_a !== 1'b0 || gc_a !== 16'd0) begin
      errors++; $display("FAIL arst_hold got wa=%b gc=%0d want 0/0", wa_a, gc_a);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tick(1, 0);
    for (int c = 0; c < 24; c++) begin
      checks++;
      if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
        errors++;
        $display("FAIL arst_restart c=%0d got=%h/%h want=%h/%h",
                 c, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
      tick(0, 0);
    end
    drain();
  endtask

  task automatic test_start_with_stop();
    for (int c = 0; c < 4; c++) begin
      tick(1, 1);
      checks++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0 || obs_a !== exp_vec(0)) begin
        errors++;
        $display("FAIL start_stop c=%0d got busy=%b%b want busy=00", c, busy_a, busy_b);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) step_mode = 1'($urandom_range(0, 1));
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
      checks++;
      if (obs_a !== exp_vec(0)) begin
        errors++; $display("FAIL rand_a c=%0d got=%h want=%h", c, obs_a, exp_vec(0));
      end
      checks++;
      if (obs_b !== exp_vec(1)) begin
        errors++; $display("FAIL rand_b c=%0d got=%h want=%h", c, obs_b, exp_vec(1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_step_mode();
    test_back_to_back();
    test_stop();
    test_async_reset();
    test_start_with_stop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
